// File: rtl/draw_pixel_sink.sv
// Pixel draw stream sink: clips, linearises and buffers pixels, then drives the
// framebuffer write port; a frame-clear sequencer takes the port at frame start.
module draw_pixel_sink #(
    parameter int                    SCREEN_W    = 320,
    parameter int                    SCREEN_H    = 240,
    parameter int                    COLOR_BITS  = 9,
    parameter int                    FB_ADDRW    = 17,
    parameter int                    FIFO_DEPTH  = 16,
    parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Draw_X,
    input  logic [31:0]           Draw_Y,
    input  logic [31:0]           Draw_Color,
    input  logic                  Enable_Draw,
    input  logic                  start_frame,
    output logic                  fb_wr_en,
    output logic [FB_ADDRW-1:0]   fb_wr_addr,
    output logic [COLOR_BITS-1:0] fb_wr_data,
    output logic                  clearing,
    output logic                  idle,
    output logic                  overflow,
    output logic [15:0]           clip_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = FB_ADDRW + COLOR_BITS;
    localparam logic [PTR_W:0]      FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [FB_ADDRW-1:0] LAST_ADDR  = FB_ADDRW'(SCREEN_W * SCREEN_H - 1);
    localparam logic [31:0]         W32        = 32'(SCREEN_W);
    localparam logic [31:0]         H32        = 32'(SCREEN_H);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t                  state_reg;
    logic [FB_ADDRW-1:0]     clear_addr_reg;
    logic                    s1_valid_reg;
    logic [FB_ADDRW-1:0]     s1_addr_reg;
    logic [COLOR_BITS-1:0]   s1_color_reg;
    logic [ENTRY_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [PTR_W:0]          count_reg;

    logic                    in_bounds;
    logic [31:0]             lin_addr;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [ENTRY_W-1:0]      head;
    logic                    unused_bits;

    // Full 32-bit compares so huge coordinates cannot alias into the screen.
    assign in_bounds   = (Draw_X < W32) && (Draw_Y < H32);
    assign lin_addr    = Draw_Y * W32 + Draw_X;
    assign unused_bits = ^{Draw_Color[31:COLOR_BITS], lin_addr[31:FB_ADDRW]};

    assign fifo_full = (count_reg == FULL_COUNT);
    // A start_frame in IDLE defers the pop so the head entry stays queued.
    assign pop       = (state_reg == ST_IDLE) && !start_frame && (count_reg != '0);
    assign push      = s1_valid_reg && (!fifo_full || pop);
    assign drop      = s1_valid_reg && fifo_full && !pop;
    assign head      = fifo_mem[rd_ptr_reg];

    assign idle = (state_reg == ST_IDLE) && !s1_valid_reg && (count_reg == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            s1_addr_reg  <= '0;
            s1_color_reg <= '0;
            clip_count   <= '0;
        end else begin
            s1_valid_reg <= Enable_Draw && in_bounds;
            if (Enable_Draw && in_bounds) begin
                s1_addr_reg  <= lin_addr[FB_ADDRW-1:0];
                s1_color_reg <= Draw_Color[COLOR_BITS-1:0];
            end
            if (Enable_Draw && !in_bounds && clip_count != 16'hFFFF)
                clip_count <= clip_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {s1_addr_reg, s1_color_reg};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (!push && pop)
                count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            clear_addr_reg <= '0;
            fb_wr_en       <= 1'b0;
            fb_wr_addr     <= '0;
            fb_wr_data     <= '0;
            clearing       <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            fb_wr_en <= 1'b0;
            clearing <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_frame) begin
                        state_reg      <= ST_CLEAR;
                        clear_addr_reg <= '0;
                    end else if (pop) begin
                        fb_wr_en   <= 1'b1;
                        fb_wr_addr <= head[ENTRY_W-1:COLOR_BITS];
                        fb_wr_data <= head[COLOR_BITS-1:0];
                    end
                end
                ST_CLEAR: begin
                    fb_wr_en   <= 1'b1;
                    clearing   <= 1'b1;
                    fb_wr_addr <= clear_addr_reg;
                    fb_wr_data <= CLEAR_COLOR;
                    if (start_frame)
                        clear_addr_reg <= '0;
                    else if (clear_addr_reg == LAST_ADDR)
                        state_reg <= ST_IDLE;
                    else
                        clear_addr_reg <= clear_addr_reg + 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
            // A drop on the same edge as start_frame is newer news, so it sticks.
            if (drop)
                overflow <= 1'b1;
            else if (start_frame)
                overflow <= 1'b0;
        end
    end

endmodule
